// File: rtl/mesi_bus_controller.sv
// MESI shared-bus responder: arbitrates CPU block requests, snoops peers,
// sources data by cache-to-cache transfer or from L2, writes back dirty data.
module mesi_bus_controller #(
  parameter int N_CPUS     = 2,
  parameter int BLOCK_SIZE = 2,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic [N_CPUS-1:0]                   dREN,
  input  logic [N_CPUS-1:0]                   dWEN,
  input  logic [N_CPUS-1:0]                   ccwrite,
  input  logic [N_CPUS*ADDR_WIDTH-1:0]        daddr,
  input  logic [N_CPUS*32*BLOCK_SIZE-1:0]     dstore,
  input  logic [N_CPUS-1:0]                   ccsnoopdone,
  input  logic [N_CPUS-1:0]                   ccsnoophit,
  input  logic [N_CPUS-1:0]                   ccdirty,
  output logic [N_CPUS-1:0]                   dwait,
  output logic [N_CPUS*32*BLOCK_SIZE-1:0]     dload,
  output logic [N_CPUS-1:0]                   ccwait,
  output logic [N_CPUS-1:0]                   ccinv,
  output logic [N_CPUS*ADDR_WIDTH-1:0]        ccsnoopaddr,
  output logic [N_CPUS-1:0]                   ccexclusive,
  output logic [ADDR_WIDTH-1:0]               l2_addr,
  output logic                                l2_ren,
  output logic                                l2_wen,
  output logic [32*BLOCK_SIZE-1:0]            l2_store,
  input  logic [32*BLOCK_SIZE-1:0]            l2_load,
  input  logic                                l2_busy
);

  localparam int BW = 32 * BLOCK_SIZE;
  localparam int PW = (N_CPUS > 1) ? $clog2(N_CPUS) : 1;
  localparam int NA = 1 << PW;

  typedef enum logic [2:0] {
    IDLE, ARB, SNOOP, XFER_WB, MEM_RD, MEM_WR, DONE
  } state_t;

  state_t                  r_state;
  logic [PW-1:0]           r_rr;
  logic [PW-1:0]           r_id;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_ccw;
  logic [BW-1:0]           r_block;
  logic [N_CPUS-1:0]       r_sdone;
  logic [N_CPUS-1:0]       r_shit;
  logic [N_CPUS-1:0]       r_sdirty;
  logic [N_CPUS-1:0]       r_dwait;
  logic [BW-1:0]           r_dload;
  logic [N_CPUS-1:0]       r_ccwait;
  logic [N_CPUS-1:0]       r_ccinv;
  logic [N_CPUS-1:0]       r_ccexcl;
  logic [ADDR_WIDTH-1:0]   r_snaddr;
  logic [ADDR_WIDTH-1:0]   r_l2_addr;
  logic                    r_l2_ren;
  logic                    r_l2_wen;
  logic [BW-1:0]           r_l2_store;

  logic [N_CPUS-1:0]       w_req;
  logic                    w_found;
  logic [PW-1:0]           w_gnt;
  logic [N_CPUS-1:0]       w_gmask;
  logic [N_CPUS-1:0]       w_idmask;
  logic [ADDR_WIDTH-1:0]   w_addr_a [NA];
  logic [BW-1:0]           w_data_a [NA];
  logic [N_CPUS-1:0]       w_sdone;
  logic [N_CPUS-1:0]       w_shit;
  logic [N_CPUS-1:0]       w_sdirty;
  logic [N_CPUS-1:0]       w_hits;
  logic                    w_alldone;
  logic                    w_anyhit;
  logic [PW-1:0]           w_sup;
  logic                    w_supdirty;
  logic                    w_fin;
  logic [BW-1:0]           w_fin_blk;
  logic                    w_fin_excl;

  assign w_req       = dREN | dWEN;
  assign dwait       = r_dwait;
  assign dload       = {N_CPUS{r_dload}};
  assign ccwait      = r_ccwait;
  assign ccinv       = r_ccinv;
  assign ccsnoopaddr = {N_CPUS{r_snaddr}};
  assign ccexclusive = r_ccexcl;
  assign l2_addr     = r_l2_addr;
  assign l2_ren      = r_l2_ren;
  assign l2_wen      = r_l2_wen;
  assign l2_store    = r_l2_store;

  // Unpack per-CPU address and data buses into indexable arrays
  always_comb begin
    for (int i = 0; i < NA; i++) begin
      w_addr_a[i] = '0;
      w_data_a[i] = '0;
    end
    for (int i = 0; i < N_CPUS; i++) begin
      w_addr_a[i] = daddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      w_data_a[i] = dstore[i*BW +: BW];
    end
  end

  // Round-robin grant: first requester at or after r_rr, then wrap
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int i = 0; i < N_CPUS; i++) begin
      if (!w_found && w_req[i] && i >= int'(r_rr)) begin
        w_found = 1'b1;
        w_gnt   = PW'(i);
      end
    end
    for (int i = 0; i < N_CPUS; i++) begin
      if (!w_found && w_req[i]) begin
        w_found = 1'b1;
        w_gnt   = PW'(i);
      end
    end
  end

  // Snoop bookkeeping: sticky responses and lowest-index supplier
  always_comb begin
    for (int i = 0; i < N_CPUS; i++) begin
      w_gmask[i]  = (PW'(i) == w_gnt);
      w_idmask[i] = (PW'(i) == r_id);
    end
    w_sdone    = r_sdone | ccsnoopdone;
    w_shit     = r_shit | (ccsnoopdone & ccsnoophit);
    w_sdirty   = r_sdirty | (ccsnoopdone & ccdirty);
    w_alldone  = &(w_sdone | w_idmask);
    w_hits     = w_shit & ~w_idmask;
    w_anyhit   = |w_hits;
    w_sup      = '0;
    for (int i = N_CPUS - 1; i >= 0; i--) begin
      if (w_hits[i]) w_sup = PW'(i);
    end
    w_supdirty = w_sdirty[w_sup];
  end

  // Completion condition and the block/exclusive values it delivers
  always_comb begin
    w_fin      = 1'b0;
    w_fin_blk  = r_block;
    w_fin_excl = 1'b0;
    case (r_state)
      SNOOP: begin
        if (w_alldone && w_anyhit && !(w_supdirty && !r_ccw)) begin
          w_fin     = 1'b1;
          w_fin_blk = w_data_a[w_sup];
        end
      end
      XFER_WB, MEM_WR: w_fin = !l2_busy;
      MEM_RD: begin
        w_fin      = !l2_busy;
        w_fin_blk  = l2_load;
        w_fin_excl = 1'b1;
      end
      default: ;
    endcase
  end

  // Bus FSM with registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_rr       <= '0;
      r_id       <= '0;
      r_addr     <= '0;
      r_ccw      <= 1'b0;
      r_block    <= '0;
      r_sdone    <= '0;
      r_shit     <= '0;
      r_sdirty   <= '0;
      r_dwait    <= '1;
      r_dload    <= '0;
      r_ccwait   <= '0;
      r_ccinv    <= '0;
      r_ccexcl   <= '0;
      r_snaddr   <= '0;
      r_l2_addr  <= '0;
      r_l2_ren   <= 1'b0;
      r_l2_wen   <= 1'b0;
      r_l2_store <= '0;
    end else begin
      r_dwait  <= '1;
      r_ccexcl <= '0;
      case (r_state)
        IDLE: begin
          if (|w_req) r_state <= ARB;
        end
        ARB: begin
          if (!w_found) begin
            r_state <= IDLE;
          end else begin
            r_id     <= w_gnt;
            r_addr   <= w_addr_a[w_gnt];
            r_ccw    <= ccwrite[w_gnt];
            r_sdone  <= '0;
            r_shit   <= '0;
            r_sdirty <= '0;
            if (int'(w_gnt) == N_CPUS - 1) r_rr <= '0;
            else                           r_rr <= w_gnt + 1'b1;
            if (dWEN[w_gnt]) begin
              r_state    <= MEM_WR;
              r_l2_wen   <= 1'b1;
              r_l2_addr  <= w_addr_a[w_gnt];
              r_l2_store <= w_data_a[w_gnt];
            end else if (N_CPUS == 1) begin
              r_state   <= MEM_RD;
              r_l2_ren  <= 1'b1;
              r_l2_addr <= w_addr_a[w_gnt];
            end else begin
              r_state  <= SNOOP;
              r_ccwait <= ~w_gmask;
              r_ccinv  <= ccwrite[w_gnt] ? ~w_gmask : '0;
              r_snaddr <= w_addr_a[w_gnt];
            end
          end
        end
        SNOOP: begin
          r_sdone  <= w_sdone;
          r_shit   <= w_shit;
          r_sdirty <= w_sdirty;
          if (w_alldone) begin
            if (!w_anyhit) begin
              r_state   <= MEM_RD;
              r_l2_ren  <= 1'b1;
              r_l2_addr <= r_addr;
            end else begin
              r_block <= w_data_a[w_sup];
              if (w_supdirty && !r_ccw) begin
                r_state    <= XFER_WB;
                r_l2_wen   <= 1'b1;
                r_l2_addr  <= r_addr;
                r_l2_store <= w_data_a[w_sup];
              end
            end
          end
        end
        MEM_RD: begin
          if (!l2_busy) r_block <= l2_load;
        end
        XFER_WB, MEM_WR: ;
        DONE: begin
          r_state  <= IDLE;
          r_ccwait <= '0;
          r_ccinv  <= '0;
        end
        default: r_state <= IDLE;
      endcase
      if (w_fin) begin
        r_state  <= DONE;
        r_dwait  <= ~w_idmask;
        r_dload  <= w_fin_blk;
        r_ccexcl <= w_fin_excl ? w_idmask : '0;
        r_ccwait <= '0;
        r_ccinv  <= '0;
        r_l2_ren <= 1'b0;
        r_l2_wen <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mesi_bus_controller.sv
// Self-checking bench for mesi_bus_controller: directed and random
// transactions against a rule-level reference model.
module tb_mesi_bus_controller;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int BW = 64;

  logic            CLK = 1'b0;
  logic            RST;
  logic [N-1:0]    dREN, dWEN, ccwrite;
  logic [N*AW-1:0] daddr;
  logic [N*BW-1:0] dstore;
  logic [N-1:0]    ccsnoopdone, ccsnoophit, ccdirty;
  logic [N-1:0]    dwait, ccwait, ccinv, ccexclusive;
  logic [N*BW-1:0] dload;
  logic [N*AW-1:0] ccsnoopaddr;
  logic [AW-1:0]   l2_addr;
  logic            l2_ren, l2_wen, l2_busy;
  logic [BW-1:0]   l2_store, l2_load;

  mesi_bus_controller #(.N_CPUS(N), .BLOCK_SIZE(2), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST(RST), .dREN(dREN), .dWEN(dWEN), .ccwrite(ccwrite),
    .daddr(daddr), .dstore(dstore), .ccsnoopdone(ccsnoopdone),
    .ccsnoophit(ccsnoophit), .ccdirty(ccdirty), .dwait(dwait),
    .dload(dload), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr), .ccexclusive(ccexclusive),
    .l2_addr(l2_addr), .l2_ren(l2_ren), .l2_wen(l2_wen),
    .l2_store(l2_store), .l2_load(l2_load), .l2_busy(l2_busy)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int rr_m   = 0;

  logic [1:0]    t_ren, t_wen, t_ccw;
  logic [AW-1:0] t_addr [2];
  logic [BW-1:0] t_data [2];
  logic          t_hit, t_dirty;
  int            t_d, t_busy;
  logic [BW-1:0] t_l2;

  task automatic chk(input string tag, input logic [BW-1:0] obs,
                     input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_dwait"}, dwait, 2'b11);
    chk({p, "_ccwait"}, ccwait, 0);
    chk({p, "_ccinv"}, ccinv, 0);
    chk({p, "_ccexcl"}, ccexclusive, 0);
    chk({p, "_l2_ren"}, l2_ren, 0);
    chk({p, "_l2_wen"}, l2_wen, 0);
    chk({p, "_dload"}, dload[BW-1:0] | dload[2*BW-1:BW], 0);
    chk({p, "_l2_addr"}, l2_addr, 0);
    chk({p, "_l2_store"}, l2_store, 0);
    chk({p, "_snaddr"}, ccsnoopaddr, 0);
  endtask

  task automatic run_txn();
    int g, o, exp_lat, done_cyc, scnt, l2c;
    bit wb, e_w, e_r, e_ex;
    logic [AW-1:0] e_wa;
    logic [BW-1:0] e_ws, e_ld;
    bit saw_r, saw_w, saw_cw, both, cw_req, odw, sresp;
    logic inv_v;
    logic [AW-1:0] ra, wa, sa0, sa1;
    logic [BW-1:0] ws, ld0, ld1;
    logic [N-1:0] ex_v, cw_done;
    logic [1:0] req;
    req = t_ren | t_wen;
    g = req[rr_m] ? rr_m : (rr_m + 1) % 2;
    o = 1 - g;
    rr_m = (g + 1) % 2;
    wb = t_wen[g];
    e_w = 0; e_r = 0; e_ex = 0; e_wa = t_addr[g]; e_ws = '0; e_ld = '0;
    if (wb) begin
      e_w = 1; e_ws = t_data[g]; exp_lat = 3 + t_busy;
    end else if (!t_hit) begin
      e_r = 1; e_ld = t_l2; e_ex = 1; exp_lat = 4 + t_d + t_busy;
    end else if (t_dirty && !t_ccw[g]) begin
      e_w = 1; e_ws = t_data[o]; e_ld = t_data[o];
      exp_lat = 4 + t_d + t_busy;
    end else begin
      e_ld = t_data[o]; exp_lat = 3 + t_d;
    end
    dREN = t_ren; dWEN = t_wen; ccwrite = t_ccw;
    daddr = {t_addr[1], t_addr[0]};
    dstore = {t_data[1], t_data[0]};
    l2_load = t_l2;
    saw_r = 0; saw_w = 0; saw_cw = 0; both = 0; cw_req = 0; odw = 0;
    sresp = 0; scnt = 0; l2c = 0; done_cyc = 0; inv_v = 1'bx;
    ra = '0; wa = '0; ws = '0; sa0 = '0; sa1 = '0;
    ld0 = '0; ld1 = '0; ex_v = '0; cw_done = '0;
    for (int cyc = 1; cyc <= 300 && done_cyc == 0; cyc++) begin
      @(posedge CLK); #1;
      if (l2_ren && l2_wen) both = 1;
      if (l2_wen && !saw_w) begin saw_w = 1; wa = l2_addr; ws = l2_store; end
      if (l2_ren && !saw_r) begin saw_r = 1; ra = l2_addr; end
      if (ccwait[g]) cw_req = 1;
      if (dwait[o] !== 1'b1) odw = 1;
      if (ccwait[o] && !saw_cw) begin
        saw_cw = 1; inv_v = ccinv[o];
        sa0 = ccsnoopaddr[AW-1:0]; sa1 = ccsnoopaddr[2*AW-1:AW];
      end
      if (dwait[g] == 1'b0) begin
        done_cyc = cyc;
        ld0 = dload[BW-1:0]; ld1 = dload[2*BW-1:BW];
        ex_v = ccexclusive; cw_done = ccwait;
      end
      if (ccwait[o] && !sresp) begin
        if (scnt == t_d) begin
          ccsnoopdone[o] = 1'b1; ccsnoophit[o] = t_hit;
          ccdirty[o] = t_dirty; sresp = 1;
        end else begin
          scnt++; ccsnoopdone = '0;
        end
      end else begin
        ccsnoopdone = '0; ccsnoophit = '0; ccdirty = '0;
      end
      if (l2_ren || l2_wen) begin
        l2_busy = (l2c < t_busy); l2c++;
      end else begin
        l2_busy = 1'b1; l2c = 0;
      end
    end
    dREN = '0; dWEN = '0; ccwrite = '0;
    ccsnoopdone = '0; ccsnoophit = '0; ccdirty = '0;
    chk("completed", done_cyc > 0, 1);
    chk("latency", done_cyc, exp_lat);
    if (!wb) begin
      chk("dload_lo", ld0, e_ld);
      chk("dload_hi", ld1, e_ld);
      chk("inv", inv_v, t_ccw[g]);
      chk("snaddr_lo", sa0, t_addr[g]);
      chk("snaddr_hi", sa1, t_addr[g]);
    end
    chk("ccexcl", ex_v, e_ex ? (2'b01 << g) : 2'b00);
    chk("l2_wen_seen", saw_w, e_w);
    chk("l2_ren_seen", saw_r, e_r);
    if (e_w) begin
      chk("l2_waddr", wa, e_wa);
      chk("l2_wdata", ws, e_ws);
    end
    if (e_r) chk("l2_raddr", ra, t_addr[g]);
    chk("ccwait_other", saw_cw, !wb);
    chk("ccwait_req", cw_req, 0);
    chk("l2_both", both, 0);
    chk("dwait_other", odw, 0);
    chk("ccwait_at_done", cw_done, 0);
    @(posedge CLK); #1;
    chk("dwait_one_cycle", dwait, 2'b11);
  endtask

  task automatic setup(input logic [1:0] ren, wen, ccw, input logic [AW-1:0] a,
                       input logic [BW-1:0] d0, d1, input logic hit, dirty,
                       input int d, busy, input logic [BW-1:0] l2);
    t_ren = ren; t_wen = wen; t_ccw = ccw;
    t_addr[0] = a; t_addr[1] = a;
    t_data[0] = d0; t_data[1] = d1;
    t_hit = hit; t_dirty = dirty; t_d = d; t_busy = busy; t_l2 = l2;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got, bad;
    RST = 1'b1;
    dREN = '0; dWEN = '0; ccwrite = '0; daddr = '0; dstore = '0;
    ccsnoopdone = '0; ccsnoophit = '0; ccdirty = '0;
    l2_busy = 1'b1; l2_load = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk_reset("reset");
    RST = 1'b0;

    setup(2'b01, 2'b00, 2'b00, 32'h100, 64'h0, 64'h0, 0, 0, 0, 2,
          64'hAAAA_BBBB_CCCC_DDDD);
    run_txn();
    setup(2'b01, 2'b00, 2'b00, 32'h100, 64'h0, 64'h1234, 1, 0, 1, 0, 64'h9);
    run_txn();
    setup(2'b01, 2'b00, 2'b00, 32'h100, 64'h0, 64'h55, 1, 1, 0, 1, 64'h9);
    run_txn();
    setup(2'b01, 2'b00, 2'b01, 32'h100, 64'h0, 64'h55, 1, 1, 0, 1, 64'h9);
    run_txn();
    for (int k = 0; k < 4; k++) begin
      setup(2'b11, 2'b00, 2'b00, 32'h140 + k * 64, 64'h0, 64'h0, 0, 0,
            k % 2, 0, 64'h1000 + k);
      run_txn();
    end
    setup(2'b11, 2'b10, 2'b00, 32'h180, 64'h77, 64'h88, 0, 0, 0, 0, 64'h5);
    run_txn();
    setup(2'b00, 2'b10, 2'b00, 32'h200, 64'h0, 64'hFEED, 0, 0, 0, 0, 64'h0);
    run_txn();

    for (int k = 0; k < 40; k++) begin
      t_ren = 2'($urandom); t_wen = 2'($urandom); t_ccw = 2'($urandom);
      if ((t_ren | t_wen) == 2'b00) t_ren[$urandom_range(1, 0)] = 1'b1;
      t_addr[0] = $urandom & 32'hFFFF_FFF8;
      t_addr[1] = $urandom & 32'hFFFF_FFF8;
      t_data[0] = {$urandom, $urandom};
      t_data[1] = {$urandom, $urandom};
      t_hit = 1'($urandom); t_dirty = 1'($urandom);
      t_d = $urandom_range(3, 0); t_busy = $urandom_range(3, 0);
      t_l2 = {$urandom, $urandom};
      run_txn();
    end

    dREN = 2'b01; daddr = {32'h0, 32'h300}; l2_busy = 1'b1;
    got = 0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(posedge CLK); #1;
      if (l2_ren) got = 1;
      ccsnoopdone[1] = ccwait[1];
      ccsnoophit = '0; ccdirty = '0;
    end
    chk("rst_reach_memrd", got, 1);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    dREN = '0; ccsnoopdone = '0;
    chk_reset("midrst");
    rr_m = 0;
    bad = 0;
    repeat (5) begin
      @(posedge CLK); #1;
      if (dwait !== 2'b11 || l2_ren || l2_wen || ccwait != 0) bad = 1;
    end
    chk("no_pulse_after_rst", bad, 0);
    setup(2'b11, 2'b00, 2'b00, 32'h400, 64'h0, 64'h0, 0, 0, 0, 0, 64'h42);
    run_txn();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mesi_bus_controller.md
Name: mesi_bus_controller

Overview:
- Shared-bus responder for the per-CPU MESI coherency units.
- Arbitrates block read, read-exclusive and writeback requests from N_CPUS caches, and snoops every non-requesting cache.
- Sources data either by cache-to-cache transfer or from the L2/memory port, and writes dirty snooped data back to L2.
- Sits between all coherency units and the single L2 generic bus.

Parameters:
- N_CPUS, 2, number of coherency units attached.
- BLOCK_SIZE, 2, words per cache block; data width BW = 32*BLOCK_SIZE.
- ADDR_WIDTH, 32, address width.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- dREN  in  N_CPUS  per-CPU block read request.
- dWEN  in  N_CPUS  per-CPU block writeback request.
- ccwrite  in  N_CPUS  read is for ownership (I/S->M).
- daddr  in  N_CPUS*ADDR_WIDTH  per-CPU block address.
- dstore  in  N_CPUS*BW  writeback or snoop-supplied data.
- ccsnoopdone  in  N_CPUS  snoop response valid.
- ccsnoophit  in  N_CPUS  snooped cache holds the block.
- ccdirty  in  N_CPUS  snooped copy is M.
- dwait  out  N_CPUS  low for one cycle = request complete.
- dload  out  N_CPUS*BW  returned block (replicated to all CPUs).
- ccwait  out  N_CPUS  snoop in progress on that CPU.
- ccinv  out  N_CPUS  invalidate on snoop.
- ccsnoopaddr  out  N_CPUS*ADDR_WIDTH  snoop address (replicated).
- ccexclusive  out  N_CPUS  no other sharer; requester fills E.
- l2_addr  out  ADDR_WIDTH  L2 address.
- l2_ren  out  1  L2 read.
- l2_wen  out  1  L2 write.
- l2_store  out  BW  L2 write data.
- l2_load  in  BW  L2 read data.
- l2_busy  in  1  L2 not done.

Behaviour:
- Reset (RST high at a CLK edge):
  - state=IDLE, rr_ptr=0.
  - dwait all 1; ccwait, ccinv, ccexclusive, l2_ren, l2_wen all 0; dload, l2_addr, l2_store, ccsnoopaddr 0.
  - Reset mid-transaction abandons the transaction; no completion pulse is issued.
- States: IDLE, ARB, SNOOP, XFER_WB, MEM_RD, MEM_WR, DONE.
- IDLE: any dREN|dWEN -> ARB next cycle.
- ARB (1 cycle):
  - Round-robin grant: first CPU with a request at or after rr_ptr, wrapping at N_CPUS-1 -> 0.
  - Latch req_id, address, type (wb = dWEN, else read), ccwrite and dstore.
  - If a CPU asserts both dWEN and dREN, the writeback wins.
  - rr_ptr <= req_id+1 mod N_CPUS.
  - wb -> MEM_WR; read -> SNOOP; N_CPUS=1 read -> MEM_RD.
  - Requests dropped after grant are ignored; latched values are used.
- SNOOP:
  - ccwait[i]=1 for all i != req_id; ccsnoopaddr=latched address; ccinv[i]=latched ccwrite.
  - Each ccsnoopdone is sticky-recorded together with hit/dirty; wait until every non-requester is done.
  - A hit pulse and a done pulse in the same cycle count.
  - Next state:
    - No hit: MEM_RD.
    - Hit: supplier = lowest-index hitting CPU; latch its dstore as block.
    - Hit, supplier dirty, not ccwrite: XFER_WB.
    - Any other hit: DONE.
  - ccwait stays high until DONE so suppliers hold their data.
- XFER_WB: l2_wen=1, l2_addr=address, l2_store=block; wait while l2_busy; -> DONE.
- MEM_RD: l2_ren=1, l2_addr=address; when !l2_busy, block <= l2_load, excl <= 1; -> DONE.
- MEM_WR: l2_wen=1, l2_store=latched dstore; when !l2_busy -> DONE. No snoop, no ccwait.
- DONE (exactly 1 cycle):
  - dwait[req_id]=0; dload=block.
  - ccexclusive[req_id]=excl, which is 1 only if no snoop hit.
  - ccwait all 0 (snoopers release this cycle); ccinv 0.
  - -> IDLE.
- dwait of non-requesters stays 1 throughout.
- Latency without L2 stall:
  - Writeback: 3 cycles from request to the dwait-low cycle.
  - Cache-to-cache read: 3 cycles plus snoop response time.
- l2_ren and l2_wen are never asserted together. Only one transaction is in flight at a time.

Test Plan:
- Reset, then CPU0 dREN addr 0x100, no snoop hit, L2 returns 0xAAAA_BBBB_CCCC_DDDD after 2 busy cycles -> dload matches, ccexclusive[0]=1, dwait[0] low for 1 cycle.
- CPU1 holds 0x100 clean; CPU0 dREN -> ccwait[1]=1, ccinv[1]=0; CPU1 hit, dstore=0x1234 -> dload=0x1234, ccexclusive[0]=0, no l2 access.
- CPU1 holds 0x100 dirty with data 0x55; CPU0 read -> l2_wen with l2_store=0x55, then dload=0x55; with ccwrite=1 instead -> ccinv[1]=1 and no l2_wen.
- CPU0 and CPU1 request in the same cycle, repeatedly -> grants alternate 0,1,0,1; a CPU asserting both dWEN and dREN has its writeback serviced first.
- CPU1 dWEN addr 0x200 data 0xFEED -> l2_wen, l2_addr=0x200, ccwait stays 0; RST asserted mid-MEM_RD -> next cycle IDLE with all outputs at reset values.
